// File: rtl/mux16_rr_sched_pkg.sv
// Shared definitions for the 16-way round-robin mux select scheduler.
// Holds the FSM state encoding, the requester count and the select width.
package mux16_rr_sched_pkg;

  localparam int N_REQ = 16;
  localparam int SEL_W = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  function automatic logic [N_REQ-1:0] sel_onehot(input logic [SEL_W-1:0] s);
    return N_REQ'(1) << s;
  endfunction

endpackage

// File: rtl/mux16_rr_sched_rr_pick16.sv
// Combinational round-robin winner search: rotate the request vector so ptr
// lands at bit 0, pick the lowest set bit, then add ptr back modulo 16.
module rr_pick16
  import mux16_rr_sched_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [N_REQ-1:0] w_rot;
  logic [SEL_W-1:0] w_off;

  always_comb begin
    w_rot = N_REQ'({req, req} >> ptr);
    w_off = '0;
    found = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_off = SEL_W'(i);
        found = 1'b1;
      end
    end
    // 4-bit add wraps naturally, giving the modulo-16 index.
    idx = w_off + ptr;
  end

endmodule

// File: rtl/mux16_rr_sched.sv
// Round-robin scheduler driving the select of a shared 16:1 mux. Grants are
// bounded to MAX_HOLD cycles and always separated by a one-cycle idle gap.
module mux16_rr_sched
  import mux16_rr_sched_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [SEL_W-1:0] sel,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid
);

  localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SEL_W-1:0] r_sel;
  logic [SEL_W-1:0] w_sel_nxt;
  logic [SEL_W-1:0] r_ptr;
  logic [SEL_W-1:0] w_ptr_nxt;
  logic [3:0]       r_cnt;
  logic [3:0]       w_cnt_nxt;
  logic             w_found;
  logic [SEL_W-1:0] w_idx;
  logic             w_release;

  rr_pick16 u_pick (
    .req   (req),
    .ptr   (r_ptr),
    .found (w_found),
    .idx   (w_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_sel   <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_release   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (en && w_found) begin
          w_state_nxt = ST_GRANT;
          w_sel_nxt   = w_idx;
          w_cnt_nxt   = 4'd1;
        end
      end
      ST_GRANT: begin
        w_release = !req[r_sel] || !en || (r_cnt == HOLD_LIM);
        // Releasing always passes through IDLE, which forms the break-before-make gap.
        if (w_release) begin
          w_state_nxt = ST_IDLE;
          w_ptr_nxt   = r_sel + 4'd1;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign sel       = r_sel;
  assign gnt_valid = (r_state == ST_GRANT);
  assign gnt       = gnt_valid ? sel_onehot(r_sel) : '0;

endmodule

// File: tb/tb_mux16_rr_sched.sv
// Self-checking bench for mux16_rr_sched: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_mux16_rr_sched;

  localparam int MAX_HOLD = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        en    = 1'b0;
  logic [15:0] req   = 16'h0000;
  logic [3:0]  sel;
  logic [15:0] gnt;
  logic        gnt_valid;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Behavioural model: who owns the mux, for how long, and where the next search starts.
  bit          m_gv  = 1'b0;
  int          m_sel = 0;
  int          m_len = 0;
  int          m_ptr = 0;
  logic [15:0] m_gnt;

  always #5 clk = ~clk;

  mux16_rr_sched #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .sel       (sel),
    .gnt       (gnt),
    .gnt_valid (gnt_valid)
  );

  task automatic model_reset();
    m_gv  = 1'b0;
    m_sel = 0;
    m_len = 0;
    m_ptr = 0;
  endtask

  always @(negedge rst_n) model_reset();

  always @(posedge clk) begin
    if (!rst_n) begin
      model_reset();
    end else if (m_gv) begin
      if (!req[m_sel] || !en || m_len == MAX_HOLD) begin
        m_gv  = 1'b0;
        m_ptr = (m_sel + 1) % 16;
      end else begin
        m_len = m_len + 1;
      end
    end else if (en && req != 16'h0000) begin
      bit hit;
      hit = 1'b0;
      for (int k = 0; k < 16; k++) begin
        if (!hit && req[(m_ptr + k) % 16]) begin
          m_sel = (m_ptr + k) % 16;
          hit   = 1'b1;
        end
      end
      m_gv  = 1'b1;
      m_len = 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      m_gnt  = m_gv ? (16'd1 << m_sel) : 16'd0;
      checks = checks + 1;
      if (sel !== 4'(m_sel) || gnt_valid !== m_gv || gnt !== m_gnt) begin
        errors = errors + 1;
        $display("FAIL model t=%0t: got sel=%0d gnt_valid=%0b gnt=%h, want sel=%0d gnt_valid=%0b gnt=%h",
                 $time, sel, gnt_valid, gnt, m_sel, m_gv, m_gnt);
      end
    end
  end

  task automatic expect_out(input string name, input bit gv, input int s);
    logic [15:0] eg;
    eg = gv ? (16'd1 << s) : 16'd0;
    checks = checks + 1;
    if (gnt_valid !== gv || sel !== 4'(s) || gnt !== eg) begin
      errors = errors + 1;
      $display("FAIL %s t=%0t: got sel=%0d gnt_valid=%0b gnt=%h, want sel=%0d gnt_valid=%0b gnt=%h",
               name, $time, sel, gnt_valid, gnt, s, gv, eg);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    expect_out("reset", 1'b0, 0);
    step(1);
    rst_n = 1'b1;
  endtask

  initial begin
    step(2);
    expect_out("por", 1'b0, 0);
    chk_en = 1'b1;
    rst_n  = 1'b1;

    // Single steady requester: 1,1,1,1,0 repeating on sel 0.
    do_reset();
    en  = 1'b1;
    req = 16'h0001;
    for (int i = 0; i < 10; i++) begin
      step(1);
      expect_out("single", (i % 5) != 4, 0);
    end

    // Wrap-around between requesters 0 and 15.
    do_reset();
    req = 16'h8001;
    for (int i = 0; i < 20; i++) begin
      step(1);
      expect_out("wrap", (i % 5) != 4, ((i / 5) % 2) ? 15 : 0);
    end

    // Early drop of requester 2 after two granted cycles.
    do_reset();
    req = 16'h0024;
    step(1); expect_out("drop_a", 1'b1, 2);
    step(1); expect_out("drop_a", 1'b1, 2);
    req = 16'h0020;
    step(1); expect_out("drop_gap", 1'b0, 2);
    for (int i = 0; i < 4; i++) begin
      step(1);
      expect_out("drop_b", 1'b1, 5);
    end
    step(1); expect_out("drop_end", 1'b0, 5);

    // Enable gating.
    do_reset();
    req = 16'h0008;
    step(1); expect_out("en_grant", 1'b1, 3);
    en = 1'b0;
    step(1); expect_out("en_release", 1'b0, 3);
    req = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      step(1);
      expect_out("en_low", 1'b0, 3);
    end
    en = 1'b1;
    step(1); expect_out("en_resume", 1'b1, 4);

    // Asynchronous reset in the middle of a grant.
    step(1);
    rst_n = 1'b0;
    #2;
    expect_out("async_reset", 1'b0, 0);
    step(1);
    rst_n = 1'b1;
    step(1); expect_out("post_reset", 1'b1, 0);

    // Fairness sweep over all 16 requesters.
    do_reset();
    req = 16'hFFFF;
    en  = 1'b1;
    for (int i = 0; i < 80; i++) begin
      step(1);
      expect_out("sweep", (i % 5) != 4, i / 5);
    end

    // Randomized traffic, checked by the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 3) == 0)
          req = 16'($urandom) & 16'($urandom);
        else if ($urandom_range(0, 1) == 0)
          req[$urandom_range(0, 15)] = ~req[$urandom_range(0, 15)];
        en = ($urandom_range(0, 15) != 0);
        step(1);
      end
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
